// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: FSM encodings and default vector/nesting settings.
package int_sequencer_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_SAVE    = 3'd1;
   localparam state_t ST_VECTOR  = 3'd2;
   localparam state_t ST_RUN     = 3'd3;
   localparam state_t ST_RESTORE = 3'd4;

   localparam logic [31:0] DEF_VEC_BASE   = 32'h100;
   localparam int unsigned DEF_VEC_STRIDE = 4;
   localparam int unsigned DEF_NEST_MAX   = 2;

endpackage

// File: rtl/int_sequencer_irq_prio_enc.sv
// Combinational priority encoder: lowest set request index wins, with a valid flag.
module irq_prio_enc #(
   parameter int unsigned N_IRQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_IRQ-1:0] req,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   always_comb begin
      idx = '0;
      vld = 1'b0;
      for (int unsigned i = 0; i < N_IRQ; i++) begin
         if (req[i] && !vld) begin
            idx = IDX_W'(i);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt sequencer: latches requests, drives the array save/restore strobes and redirects fetch
// to the handler vector or the saved return PC, with a small nesting stack.
module int_sequencer
   import int_sequencer_pkg::*;
#(
   parameter int unsigned          N_IRQ      = 4,
   parameter int unsigned          ADDR_W     = 32,
   parameter int unsigned          NEST_MAX   = DEF_NEST_MAX,
   parameter logic [ADDR_W-1:0]    VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
   parameter int unsigned          VEC_STRIDE = DEF_VEC_STRIDE
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_IRQ-1:0]                irq,
   input  logic [N_IRQ-1:0]                irq_mask,
   input  logic [ADDR_W-1:0]               pc_cur,
   input  logic                            eret,
   input  logic                            stall,
   input  logic                            pipe_we_in,
   output logic                            pipe_we,
   output logic                            save_out,
   output logic                            upper_int,
   output logic                            flush,
   output logic                            load_out,
   output logic                            redirect_vld,
   output logic [ADDR_W-1:0]               redirect_pc,
   output logic                            int_active,
   output logic [$clog2(NEST_MAX+1)-1:0]   depth
);

   localparam int unsigned IDX_W   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
   localparam int unsigned DEPTH_W = $clog2(NEST_MAX + 1);

   state_t             state;
   logic [N_IRQ-1:0]   irq_q;
   logic [N_IRQ-1:0]   pend;
   logic [N_IRQ-1:0]   edges;
   logic [N_IRQ-1:0]   eligible;
   logic               armed;
   logic               eret_held;
   logic               we_pulse;
   logic [IDX_W-1:0]   sel;
   logic               sel_vld;
   logic [IDX_W-1:0]   vec_sel;
   logic [ADDR_W-1:0]  epc [NEST_MAX];
   logic [IDX_W-1:0]   lvl [NEST_MAX];
   logic [ADDR_W-1:0]  epc_top;
   logic [IDX_W-1:0]   lvl_top;
   logic               ret_req;
   logic               take_entry;
   logic               take_ret;

   // armed suppresses the false edge a line held high through reset would otherwise produce
   assign edges    = irq & ~irq_q & {N_IRQ{armed}};
   assign eligible = pend & irq_mask;

   irq_prio_enc #(
      .N_IRQ (N_IRQ),
      .IDX_W (IDX_W)
   ) u_prio (
      .req (eligible),
      .idx (sel),
      .vld (sel_vld)
   );

   always_comb begin
      epc_top = '0;
      lvl_top = '0;
      for (int unsigned i = 0; i < NEST_MAX; i++) begin
         if (depth == DEPTH_W'(i + 1)) begin
            epc_top = epc[i];
            lvl_top = lvl[i];
         end
      end
   end

   assign ret_req    = (state == ST_RUN) && (eret || eret_held);
   assign take_ret   = ret_req && !stall;
   // a pending return blocks nesting so eret always wins over a same-cycle request
   assign take_entry = sel_vld && !stall &&
                       ((state == ST_IDLE) ||
                        ((state == ST_RUN) && !ret_req &&
                         (depth < DEPTH_W'(NEST_MAX)) && (sel < lvl_top)));

   assign pipe_we    = pipe_we_in | we_pulse;
   assign int_active = (depth != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         irq_q        <= '0;
         pend         <= '0;
         armed        <= 1'b0;
         eret_held    <= 1'b0;
         we_pulse     <= 1'b0;
         save_out     <= 1'b0;
         upper_int    <= 1'b0;
         flush        <= 1'b0;
         load_out     <= 1'b0;
         redirect_vld <= 1'b0;
         redirect_pc  <= '0;
         depth        <= '0;
         vec_sel      <= '0;
         for (int unsigned i = 0; i < NEST_MAX; i++) begin
            epc[i] <= '0;
            lvl[i] <= '0;
         end
      end else begin
         irq_q        <= irq;
         armed        <= 1'b1;
         we_pulse     <= 1'b0;
         save_out     <= 1'b0;
         upper_int    <= 1'b0;
         flush        <= 1'b0;
         load_out     <= 1'b0;
         redirect_vld <= 1'b0;
         redirect_pc  <= '0;

         if (take_entry) begin
            pend <= (pend | edges) & ~(N_IRQ'(1) << sel);
         end else begin
            pend <= pend | edges;
         end

         if ((state == ST_RUN) && eret && stall) begin
            eret_held <= 1'b1;
         end

         if (take_entry) begin
            save_out  <= 1'b1;
            we_pulse  <= 1'b1;
            upper_int <= (depth != '0);
            vec_sel   <= sel;
            depth     <= depth + DEPTH_W'(1);
            for (int unsigned i = 0; i < NEST_MAX; i++) begin
               if (depth == DEPTH_W'(i)) begin
                  epc[i] <= pc_cur;
                  lvl[i] <= sel;
               end
            end
         end

         if (take_ret) begin
            eret_held    <= 1'b0;
            redirect_vld <= 1'b1;
            redirect_pc  <= epc_top;
            we_pulse     <= 1'b1;
            depth        <= depth - DEPTH_W'(1);
            if (depth == DEPTH_W'(1)) begin
               load_out <= 1'b1;
            end else begin
               flush <= 1'b1;
            end
         end

         case (state)
            ST_IDLE: begin
               if (take_entry) state <= ST_SAVE;
            end
            ST_SAVE: begin
               state        <= ST_VECTOR;
               redirect_vld <= 1'b1;
               redirect_pc  <= VEC_BASE + ADDR_W'(vec_sel) * ADDR_W'(VEC_STRIDE);
            end
            ST_VECTOR: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (take_ret) begin
                  state <= ST_RESTORE;
               end else if (take_entry) begin
                  state <= ST_SAVE;
               end
            end
            ST_RESTORE: begin
               state <= (depth == '0) ? ST_IDLE : ST_RUN;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed self-checking bench for int_sequencer: entry, nesting, priority, stall and reset cases.
module tb_int_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  irq;
   logic [3:0]  irq_mask;
   logic [31:0] pc_cur;
   logic        eret;
   logic        stall;
   logic        pipe_we_in;
   logic        pipe_we;
   logic        save_out;
   logic        upper_int;
   logic        flush;
   logic        load_out;
   logic        redirect_vld;
   logic [31:0] redirect_pc;
   logic        int_active;
   logic [1:0]  depth;

   int errors = 0;
   int checks = 0;

   int_sequencer #(
      .N_IRQ      (4),
      .ADDR_W     (32),
      .NEST_MAX   (2),
      .VEC_BASE   (32'h100),
      .VEC_STRIDE (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .irq          (irq),
      .irq_mask     (irq_mask),
      .pc_cur       (pc_cur),
      .eret         (eret),
      .stall        (stall),
      .pipe_we_in   (pipe_we_in),
      .pipe_we      (pipe_we),
      .save_out     (save_out),
      .upper_int    (upper_int),
      .flush        (flush),
      .load_out     (load_out),
      .redirect_vld (redirect_vld),
      .redirect_pc  (redirect_pc),
      .int_active   (int_active),
      .depth        (depth)
   );

   always #5 clk = ~clk;

   // strobe vector order: {save_out, upper_int, flush, load_out, redirect_vld, pipe_we}
   function automatic logic [5:0] strobes();
      return {save_out, upper_int, flush, load_out, redirect_vld, pipe_we};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ret_tick();
      eret = 1'b1;
      tick();
      eret = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; irq = 4'b0100; irq_mask = 4'hF; pc_cur = 32'h80;
      eret = 1'b0; stall = 1'b0; pipe_we_in = 1'b0;
      repeat (3) tick();
      checks++;
      if ({strobes(), redirect_pc, int_active, depth} !== '0) begin
         errors++;
         $display("FAIL reset_outputs strobes=%b pc=%h act=%b depth=%0d want all 0",
                  strobes(), redirect_pc, int_active, depth);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (strobes() !== 6'b0) begin
            errors++;
            $display("FAIL reset_no_entry cyc=%0d strobes=%b want 000000", i, strobes());
         end
      end
      irq = 4'b0000; tick();
      irq = 4'b0100; tick();
      checks++;
      if (strobes() !== 6'b0) begin
         errors++; $display("FAIL reset_edge_early strobes=%b want 000000", strobes());
      end
      tick();
      checks++;
      if (strobes() !== 6'b100001 || depth !== 2'd1) begin
         errors++; $display("FAIL reset_edge_save strobes=%b depth=%0d want 100001 1", strobes(), depth);
      end
      tick();
      checks++;
      if (strobes() !== 6'b000010 || redirect_pc !== 32'h108) begin
         errors++; $display("FAIL reset_edge_vec strobes=%b pc=%h want 000010 108", strobes(), redirect_pc);
      end
      tick();
      ret_tick();
      checks++;
      if (strobes() !== 6'b000111 || redirect_pc !== 32'h80 || depth !== 2'd0) begin
         errors++; $display("FAIL reset_edge_ret strobes=%b pc=%h depth=%0d want 000111 80 0",
                            strobes(), redirect_pc, depth);
      end
      irq = 4'b0000; tick();
   endtask

   task automatic test_single();
      pipe_we_in = 1'b1; #1;
      checks++;
      if (pipe_we !== 1'b1) begin
         errors++; $display("FAIL we_passthru pipe_we=%b want 1", pipe_we);
      end
      pipe_we_in = 1'b0;
      irq = 4'b0010; pc_cur = 32'h40;
      tick();
      checks++;
      if (strobes() !== 6'b0) begin
         errors++; $display("FAIL single_plus1 strobes=%b want 000000", strobes());
      end
      tick();
      checks++;
      if (strobes() !== 6'b100001 || depth !== 2'd1 || int_active !== 1'b1) begin
         errors++; $display("FAIL single_save strobes=%b depth=%0d act=%b want 100001 1 1",
                            strobes(), depth, int_active);
      end
      tick();
      checks++;
      if (strobes() !== 6'b000010 || redirect_pc !== 32'h104) begin
         errors++; $display("FAIL single_vec strobes=%b pc=%h want 000010 104", strobes(), redirect_pc);
      end
      tick();
      checks++;
      if (strobes() !== 6'b0) begin
         errors++; $display("FAIL single_run strobes=%b want 000000", strobes());
      end
      ret_tick();
      checks++;
      if (strobes() !== 6'b000111 || redirect_pc !== 32'h40 || depth !== 2'd0 || int_active !== 1'b0) begin
         errors++; $display("FAIL single_ret strobes=%b pc=%h depth=%0d act=%b want 000111 40 0 0",
                            strobes(), redirect_pc, depth, int_active);
      end
      irq = 4'b0000; tick();
   endtask

   task automatic test_nested();
      irq = 4'b0100; pc_cur = 32'h200;
      repeat (4) tick();
      pc_cur = 32'h300; irq = 4'b0101;
      tick(); tick();
      checks++;
      if (strobes() !== 6'b110001 || depth !== 2'd2) begin
         errors++; $display("FAIL nest_save strobes=%b depth=%0d want 110001 2", strobes(), depth);
      end
      tick();
      checks++;
      if (strobes() !== 6'b000010 || redirect_pc !== 32'h100) begin
         errors++; $display("FAIL nest_vec strobes=%b pc=%h want 000010 100", strobes(), redirect_pc);
      end
      tick();
      ret_tick();
      checks++;
      if (strobes() !== 6'b001011 || redirect_pc !== 32'h300 || depth !== 2'd1) begin
         errors++; $display("FAIL nest_ret1 strobes=%b pc=%h depth=%0d want 001011 300 1",
                            strobes(), redirect_pc, depth);
      end
      tick();
      ret_tick();
      checks++;
      if (strobes() !== 6'b000111 || redirect_pc !== 32'h200 || depth !== 2'd0) begin
         errors++; $display("FAIL nest_ret2 strobes=%b pc=%h depth=%0d want 000111 200 0",
                            strobes(), redirect_pc, depth);
      end
      irq = 4'b0000; tick();
   endtask

   task automatic test_priority();
      irq = 4'b1001; pc_cur = 32'h900;
      tick(); tick();
      checks++;
      if (strobes() !== 6'b100001 || depth !== 2'd1) begin
         errors++; $display("FAIL prio_save strobes=%b depth=%0d want 100001 1", strobes(), depth);
      end
      tick();
      checks++;
      if (redirect_pc !== 32'h100 || redirect_vld !== 1'b1) begin
         errors++; $display("FAIL prio_vec0 vld=%b pc=%h want 1 100", redirect_vld, redirect_pc);
      end
      tick(); tick();
      checks++;
      if (strobes() !== 6'b0) begin
         errors++; $display("FAIL prio_lower_waits strobes=%b want 000000", strobes());
      end
      ret_tick();
      checks++;
      if (strobes() !== 6'b000111 || redirect_pc !== 32'h900) begin
         errors++; $display("FAIL prio_ret strobes=%b pc=%h want 000111 900", strobes(), redirect_pc);
      end
      tick(); tick();
      checks++;
      if (strobes() !== 6'b100001) begin
         errors++; $display("FAIL prio_l3_save strobes=%b want 100001", strobes());
      end
      tick();
      checks++;
      if (redirect_pc !== 32'h10C) begin
         errors++; $display("FAIL prio_l3_vec pc=%h want 10c", redirect_pc);
      end
      tick();
      ret_tick();
      checks++;
      if (strobes() !== 6'b000111 || depth !== 2'd0) begin
         errors++; $display("FAIL prio_l3_ret strobes=%b depth=%0d want 000111 0", strobes(), depth);
      end
      irq = 4'b0000; tick();
   endtask

   task automatic test_eret_vs_irq();
      irq = 4'b0100; pc_cur = 32'hA00;
      repeat (4) tick();
      irq = 4'b0101; eret = 1'b1;
      tick();
      eret = 1'b0;
      checks++;
      if (strobes() !== 6'b000111 || redirect_pc !== 32'hA00 || depth !== 2'd0) begin
         errors++; $display("FAIL eret_wins strobes=%b pc=%h depth=%0d want 000111 a00 0",
                            strobes(), redirect_pc, depth);
      end
      tick();
      checks++;
      if (strobes() !== 6'b0) begin
         errors++; $display("FAIL eret_gap strobes=%b want 000000", strobes());
      end
      tick();
      checks++;
      if (strobes() !== 6'b100001 || depth !== 2'd1) begin
         errors++; $display("FAIL eret_then_entry strobes=%b depth=%0d want 100001 1", strobes(), depth);
      end
      tick();
      checks++;
      if (redirect_pc !== 32'h100) begin
         errors++; $display("FAIL eret_then_vec pc=%h want 100", redirect_pc);
      end
      tick();
      ret_tick();
      irq = 4'b0000; tick();
   endtask

   task automatic test_stall_entry();
      stall = 1'b1; irq = 4'b0010; pc_cur = 32'hC00;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (strobes() !== 6'b0) begin
            errors++; $display("FAIL stall_hold cyc=%0d strobes=%b want 000000", i, strobes());
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if (strobes() !== 6'b100001) begin
         errors++; $display("FAIL stall_release strobes=%b want 100001", strobes());
      end
      tick();
      checks++;
      if (redirect_pc !== 32'h104) begin
         errors++; $display("FAIL stall_vec pc=%h want 104", redirect_pc);
      end
      tick();
      ret_tick();
      checks++;
      if (strobes() !== 6'b000111 || redirect_pc !== 32'hC00) begin
         errors++; $display("FAIL stall_ret strobes=%b pc=%h want 000111 c00", strobes(), redirect_pc);
      end
      irq = 4'b0000; tick();
   endtask

   task automatic test_stall_eret();
      irq = 4'b0100; pc_cur = 32'hB00;
      repeat (4) tick();
      stall = 1'b1; irq = 4'b0101; eret = 1'b1;
      tick();
      eret = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (strobes() !== 6'b0) begin
            errors++; $display("FAIL stall_eret_hold cyc=%0d strobes=%b want 000000", i, strobes());
         end
         tick();
      end
      stall = 1'b0;
      tick();
      checks++;
      if (strobes() !== 6'b000111 || redirect_pc !== 32'hB00) begin
         errors++; $display("FAIL stall_eret_ret strobes=%b pc=%h want 000111 b00", strobes(), redirect_pc);
      end
      tick(); tick();
      checks++;
      if (strobes() !== 6'b100001 || depth !== 2'd1) begin
         errors++; $display("FAIL stall_eret_entry strobes=%b depth=%0d want 100001 1", strobes(), depth);
      end
      tick(); tick();
      ret_tick();
      irq = 4'b0000; tick();
   endtask

   task automatic test_nest_max();
      irq = 4'b1000; pc_cur = 32'h500;
      repeat (4) tick();
      irq = 4'b1010; pc_cur = 32'h600;
      tick(); tick();
      checks++;
      if (strobes() !== 6'b110001 || depth !== 2'd2) begin
         errors++; $display("FAIL max_save2 strobes=%b depth=%0d want 110001 2", strobes(), depth);
      end
      tick(); tick();
      irq = 4'b1011; pc_cur = 32'h700;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (strobes() !== 6'b0 || depth !== 2'd2) begin
            errors++; $display("FAIL max_blocked cyc=%0d strobes=%b depth=%0d want 000000 2",
                               i, strobes(), depth);
         end
      end
      ret_tick();
      checks++;
      if (strobes() !== 6'b001011 || redirect_pc !== 32'h600 || depth !== 2'd1) begin
         errors++; $display("FAIL max_ret1 strobes=%b pc=%h depth=%0d want 001011 600 1",
                            strobes(), redirect_pc, depth);
      end
      tick(); tick();
      checks++;
      if (strobes() !== 6'b110001 || depth !== 2'd2) begin
         errors++; $display("FAIL max_renest strobes=%b depth=%0d want 110001 2", strobes(), depth);
      end
      tick();
      checks++;
      if (redirect_pc !== 32'h100) begin
         errors++; $display("FAIL max_renest_vec pc=%h want 100", redirect_pc);
      end
      tick();
      ret_tick();
      checks++;
      if (strobes() !== 6'b001011 || redirect_pc !== 32'h700) begin
         errors++; $display("FAIL max_ret2 strobes=%b pc=%h want 001011 700", strobes(), redirect_pc);
      end
      tick();
      ret_tick();
      checks++;
      if (strobes() !== 6'b000111 || redirect_pc !== 32'h500 || depth !== 2'd0) begin
         errors++; $display("FAIL max_ret3 strobes=%b pc=%h depth=%0d want 000111 500 0",
                            strobes(), redirect_pc, depth);
      end
      irq = 4'b0000; tick();
   endtask

   task automatic test_reset_abort();
      irq = 4'b0010; pc_cur = 32'hD00;
      tick(); tick();
      checks++;
      if (strobes() !== 6'b100001) begin
         errors++; $display("FAIL abort_save strobes=%b want 100001", strobes());
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({strobes(), redirect_pc, int_active, depth} !== '0) begin
         errors++; $display("FAIL abort_outputs strobes=%b pc=%h depth=%0d want all 0",
                            strobes(), redirect_pc, depth);
      end
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if (strobes() !== 6'b0 || depth !== 2'd0) begin
         errors++; $display("FAIL abort_idle strobes=%b depth=%0d want 000000 0", strobes(), depth);
      end
      irq = 4'b0000; tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_nested();
      test_priority();
      test_eret_vs_irq();
      test_stall_entry();
      test_stall_eret();
      test_nest_max();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
